// File: rtl/serial_feeder.sv
// Parallel-to-serial stage feeding the downstream sequence detector.
// Words are loaded when ready is high and shifted out one bit per cycle; back-to-back loads leave no gap.
module serial_feeder #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    output logic             ready,
    output logic             x,
    output logic             xvalid,
    output logic             last,
    output logic [7:0]       words
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_next;
    logic [WIDTH-1:0] sreg_shifted;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_next;
    logic [7:0]       words_next;
    logic             out_bit;
    logic             cnt_zero;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
            words <= '0;
        end else begin
            state <= state_next;
            sreg  <= sreg_next;
            cnt   <= cnt_next;
            words <= words_next;
        end
    end

    assign cnt_zero     = (cnt == '0);
    assign out_bit      = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
    assign sreg_shifted = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};

    // The final bit of a word doubles as the load window, so a new word can follow with no gap.
    always_comb begin
        state_next = state;
        sreg_next  = sreg;
        cnt_next   = cnt;
        words_next = words;
        case (state)
            IDLE: begin
                if (load) begin
                    sreg_next  = din;
                    cnt_next   = CW'(WIDTH - 1);
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (!cnt_zero) begin
                    sreg_next = sreg_shifted;
                    cnt_next  = cnt - 1'b1;
                end else begin
                    words_next = words + 8'd1;
                    if (load) begin
                        sreg_next = din;
                        cnt_next  = CW'(WIDTH - 1);
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        ready  = 1'b1;
        x      = 1'b0;
        xvalid = 1'b0;
        last   = 1'b0;
        if (state == SHIFT) begin
            xvalid = 1'b1;
            x      = out_bit;
            last   = cnt_zero;
            ready  = cnt_zero;
        end
    end

endmodule

// File: tb/tb_serial_feeder.sv
// Scoreboard bench for serial_feeder: one MSB-first and one LSB-first instance share the same stimulus.
module tb_serial_feeder;

    logic       clk;
    logic       reset;
    logic [7:0] din;
    logic       load;

    logic       ready_m, x_m, xvalid_m, last_m;
    logic [7:0] words_m;
    logic       ready_l, x_l, xvalid_l, last_l;
    logic [7:0] words_l;

    logic [1:0] q_m[$];
    logic [1:0] q_l[$];
    logic [7:0] words_exp;
    int         accept_count;
    logic [15:0] cap_m;
    logic [15:0] cap_l;

    int n_checks;
    int n_fail;

    serial_feeder #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk    (clk),
        .reset  (reset),
        .din    (din),
        .load   (load),
        .ready  (ready_m),
        .x      (x_m),
        .xvalid (xvalid_m),
        .last   (last_m),
        .words  (words_m)
    );

    serial_feeder #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk    (clk),
        .reset  (reset),
        .din    (din),
        .load   (load),
        .ready  (ready_l),
        .x      (x_l),
        .xvalid (xvalid_l),
        .last   (last_l),
        .words  (words_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic pushWord(input logic [7:0] d);
        for (int i = 0; i < 8; i++) begin
            q_m.push_back({d[7-i], (i == 7)});
            q_l.push_back({d[i],   (i == 7)});
        end
    endtask

    task automatic checkSide(input string side, input logic [1:0] q_front, input int q_size,
                             input logic rdy, input logic xb, input logic xv, input logic lst,
                             input logic [7:0] wrd);
        if (q_size > 0) begin
            checkOutput({side, "_xvalid"}, 32'(xv),  32'd1);
            checkOutput({side, "_x"},      32'(xb),  32'(q_front[1]));
            checkOutput({side, "_last"},   32'(lst), 32'(q_front[0]));
            checkOutput({side, "_ready"},  32'(rdy), 32'(q_front[0]));
        end else begin
            checkOutput({side, "_xvalid"}, 32'(xv),  32'd0);
            checkOutput({side, "_x"},      32'(xb),  32'd0);
            checkOutput({side, "_last"},   32'(lst), 32'd0);
            checkOutput({side, "_ready"},  32'(rdy), 32'd1);
        end
        checkOutput({side, "_words"}, 32'(wrd), 32'(words_exp));
    endtask

    // One clock: drive inputs, advance the reference model at the edge, then compare just after it.
    task automatic applyStimulus(input logic rst_n, input logic ld, input logic [7:0] d);
        logic       ready_exp;
        logic [1:0] popped;
        reset = rst_n;
        load  = ld;
        din   = d;
        ready_exp = (q_m.size() <= 1);
        @(posedge clk);
        if (!rst_n) begin
            q_m.delete();
            q_l.delete();
            words_exp = 8'd0;
        end else begin
            if (q_m.size() > 0) begin
                popped = q_m.pop_front();
                void'(q_l.pop_front());
                if (popped[0]) words_exp = words_exp + 8'd1;
            end
            if (ld && ready_exp) begin
                pushWord(d);
                accept_count++;
            end
        end
        #1;
        checkSide("msb", (q_m.size() > 0) ? q_m[0] : 2'b00, q_m.size(),
                  ready_m, x_m, xvalid_m, last_m, words_m);
        checkSide("lsb", (q_l.size() > 0) ? q_l[0] : 2'b00, q_l.size(),
                  ready_l, x_l, xvalid_l, last_l, words_l);
        if (xvalid_m) cap_m = {cap_m[14:0], x_m};
        if (xvalid_l) cap_l = {cap_l[14:0], x_l};
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        words_exp    = 8'd0;
        accept_count = 0;
        cap_m        = '0;
        cap_l        = '0;
        reset        = 1'b0;
        load         = 1'b0;
        din          = '0;

        // Reset held with a load pending must not capture anything.
        applyStimulus(1'b0, 1'b1, 8'hFF);
        applyStimulus(1'b0, 1'b1, 8'hFF);
        checkOutput("rst_ready", 32'(ready_m), 32'd1);
        checkOutput("rst_words", 32'(words_m), 32'd0);

        // Single word, then idle.
        applyStimulus(1'b1, 1'b1, 8'b1001_0000);
        for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("single_bits", 32'(cap_m[7:0]), 32'h90);
        checkOutput("single_words", 32'(words_m), 32'd1);

        // Back-to-back words via a load during the last bit.
        applyStimulus(1'b1, 1'b1, 8'hA5);
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b1, 8'h3C);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("b2b_bits", 32'(cap_m), 32'hA53C);
        checkOutput("b2b_words", 32'(words_m), 32'd3);

        // A load mid-word is ignored.
        applyStimulus(1'b1, 1'b1, 8'h00);
        applyStimulus(1'b1, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b1, 8'hFF);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("ignore_bits", 32'(cap_m[7:0]), 32'h00);
        checkOutput("ignore_words", 32'(words_m), 32'd4);

        // Reset in the middle of a word discards the rest of it.
        applyStimulus(1'b1, 1'b1, 8'hF0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("abort_xvalid", 32'(xvalid_m), 32'd0);
        checkOutput("abort_words", 32'(words_m), 32'd0);

        // Load in the very first cycle after reset; LSB-first order check.
        applyStimulus(1'b1, 1'b1, 8'b0000_1001);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("lsb_bits", 32'(cap_l[7:0]), 32'b1001_0000);
        checkOutput("msb_bits09", 32'(cap_m[7:0]), 32'h09);
        checkOutput("post_rst_words", 32'(words_m), 32'd1);

        // 255 more words back-to-back wrap the counter to zero.
        accept_count = 0;
        for (int k = 0; k < 4000 && accept_count < 255; k++)
            applyStimulus(1'b1, 1'b1, 8'($urandom_range(0, 255)));
        checkOutput("wrap_accepts", 32'(accept_count), 32'd255);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("wrap_words_m", 32'(words_m), 32'd0);
        checkOutput("wrap_words_l", 32'(words_l), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_feeder.md
SERIAL_FEEDER -- requirements
Module: serial_feeder

Upstream parallel-to-serial stage that produces the bit stream consumed by the sequence-detector FSM (drives its x input).

Interface
REQ-001 Parameter WIDTH, default 8, meaning word length in bits (legal range 2..16).
REQ-002 Parameter MSB_FIRST, default 1, meaning 1 = shift out bit WIDTH-1 first, 0 = bit 0 first.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 din  input  WIDTH  parallel word to serialize.
REQ-006 load  input  1  request to capture din; honoured only when ready=1.
REQ-007 ready  output  1  block can accept a word at the next clk edge.
REQ-008 x  output  1  serial data bit to the downstream detector.
REQ-009 xvalid  output  1  x carries a valid data bit this cycle.
REQ-010 last  output  1  the current x is the final bit of the word.
REQ-011 words  output  8  count of completely transmitted words, modulo 256.

Function
REQ-012 Two-state FSM: IDLE and SHIFT; state, shift register sreg[WIDTH-1:0], bit counter cnt and words are registered.
REQ-013 In IDLE: ready=1, xvalid=0, last=0, x=0.
REQ-014 In SHIFT: xvalid=1; x = sreg[WIDTH-1] if MSB_FIRST=1, else sreg[0]; last = (cnt==0); ready = last.
REQ-015 IDLE with load=1 at an edge: sreg<=din, cnt<=WIDTH-1, next state SHIFT; the first bit appears on x in the cycle following that edge (one-cycle latency).
REQ-016 IDLE with load=0: remain in IDLE; sreg and cnt hold.
REQ-017 SHIFT with cnt!=0 at an edge: sreg shifts one position toward the output end (zero fill), cnt<=cnt-1; load is ignored and din is not captured.
REQ-018 SHIFT with cnt==0 and load=1 at an edge: words<=words+1, sreg<=din, cnt<=WIDTH-1, stay in SHIFT, so there is no idle gap between words.
REQ-019 SHIFT with cnt==0 and load=0 at an edge: words<=words+1, next state IDLE.
REQ-020 Exactly WIDTH consecutive xvalid cycles per accepted word; bits are never dropped, duplicated or reordered except by reset.
REQ-021 words wraps from 255 to 0 without saturation or a flag.
REQ-022 Outputs ready, x, xvalid and last are decoded from registered state only; no combinational path from din or load to any output.

Reset
REQ-023 reset=0 at a clk edge forces state IDLE, sreg=0, cnt=0, words=0, regardless of load or current state.
REQ-024 Reset during SHIFT aborts the word: remaining bits are discarded, and the aborted word is not counted.
REQ-025 The cycle after reset deasserts, ready=1, xvalid=0 and x=0; a load in that first cycle is accepted normally.

Verification
REQ-026 Hold reset=0 for 2 edges with load=1 and din=8'hFF -> ready=1, xvalid=0, x=0, last=0, words=0; no word captured.
REQ-027 From IDLE, load din=8'b1001_0000 (MSB_FIRST=1) for one cycle -> x=1,0,0,1,0,0,0,0 on the next 8 cycles with xvalid=1 and last=1 on the 8th only; then IDLE, words=1; a downstream detector fed with x asserts y exactly once.
REQ-028 Load 8'hA5, then hold load=1 with din=8'h3C during the last bit -> 16 consecutive valid bits 1010_0101_0011_1100 with no gap, words=2 afterwards.
REQ-029 Pulse load=1 with din=8'hFF during bit 3 of an 8'h00 word -> the pulse is ignored; x stays 0 for all 8 bits; words increments by 1 only.
REQ-030 Assert reset=0 for one edge during bit 4 of a word -> IDLE next cycle, xvalid=0, words=0, remaining bits are never emitted.
REQ-031 MSB_FIRST=0, load 8'b0000_1001 -> x=1,0,0,1,0,0,0,0; separately, send 256 words back-to-back -> words returns to 0.
